// File: rtl/lcd_bus_monitor.sv
// -----------------------------------------------------------------------------
// lcd_bus_monitor
// Passive receiver for an HD44780-style parallel LCD bus. It decodes every
// falling EN strobe as an instruction or a data write and keeps a 2x16 shadow
// of the visible DDRAM.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   LCD_DATA[7:0]     bus data
//   LCD_RS            0 = instruction, 1 = data
//   LCD_RW            0 = write, 1 = read (reads are ignored)
//   LCD_EN            strobe, acted on at its falling edge
//   LCD_ON            panel power, strobes ignored while low
//   line_1/line_2     shadow of DDRAM 0x00-0x0F / 0x40-0x4F, index 0 = leftmost
//   addr              DDRAM address counter
//   display_on        D bit of the last Display Control instruction
//   frame_done        one-cycle pulse on a data write landing at 0x4F
//   err_4bit          sticky, Function Set seen with DL = 0
//   err_addr          sticky, Set DDRAM Address outside the valid ranges
// -----------------------------------------------------------------------------
module lcd_bus_monitor #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        LCD_DATA,
    input  logic              LCD_RS,
    input  logic              LCD_RW,
    input  logic              LCD_EN,
    input  logic              LCD_ON,
    output logic [15:0][7:0]  line_1,
    output logic [15:0][7:0]  line_2,
    output logic [6:0]        addr,
    output logic              display_on,
    output logic              frame_done,
    output logic              err_4bit,
    output logic              err_addr
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int BUS_W  = 12;

    // Bus packing inside the synchroniser: {on, en, rs, rw, data[7:0]}
    logic [STAGES-1:0][BUS_W-1:0] sync_r;
    logic [BUS_W-1:0]             bus_s;
    logic                         en_prev_r;
    logic                         strobe_s;
    logic                         inc_mode_r;
    logic                         cgram_mode_r;

    logic [15:0][7:0] line_1_s;
    logic [15:0][7:0] line_2_s;
    logic [6:0]       addr_s;
    logic             display_on_s;
    logic             frame_done_s;
    logic             err_4bit_s;
    logic             err_addr_s;
    logic             inc_mode_s;
    logic             cgram_mode_s;

    // DDRAM addresses that exist on a 2-line controller
    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Increment with the 2-line wrap (end of line 1 -> line 2 -> line 1)
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        if (a == 7'h27) begin
            return 7'h40;
        end else if (a == 7'h67) begin
            return 7'h00;
        end else begin
            return a + 7'd1;
        end
    endfunction

    // Decrement with the 2-line wrap
    function automatic logic [6:0] addr_dec(input logic [6:0] a);
        if (a == 7'h00) begin
            return 7'h67;
        end else if (a == 7'h40) begin
            return 7'h27;
        end else begin
            return a - 7'd1;
        end
    endfunction

    assign bus_s    = sync_r[STAGES-1];
    assign strobe_s = en_prev_r & ~bus_s[10];

    // Input synchroniser chain and EN history for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r    <= '0;
            en_prev_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[STAGES-2:0], {LCD_ON, LCD_EN, LCD_RS, LCD_RW, LCD_DATA}};
            en_prev_r <= bus_s[10];
        end
    end

    // Decode of one strobe into the next shadow/address/flag state
    always_comb begin
        line_1_s     = line_1;
        line_2_s     = line_2;
        addr_s       = addr;
        display_on_s = display_on;
        frame_done_s = 1'b0;
        err_4bit_s   = err_4bit;
        err_addr_s   = err_addr;
        inc_mode_s   = inc_mode_r;
        cgram_mode_s = cgram_mode_r;

        if (strobe_s && bus_s[11] && !bus_s[8]) begin
            if (!bus_s[9]) begin
                casez (bus_s[7:0])
                    8'b1???????: begin
                        addr_s       = bus_s[6:0];
                        cgram_mode_s = 1'b0;
                        if (!addr_valid(bus_s[6:0])) begin
                            err_addr_s = 1'b1;
                        end else begin
                            err_addr_s = err_addr;
                        end
                    end
                    8'b01??????: cgram_mode_s = 1'b1;
                    8'b001?????: begin
                        if (!bus_s[4]) begin
                            err_4bit_s = 1'b1;
                        end else begin
                            err_4bit_s = err_4bit;
                        end
                    end
                    8'b0001????: begin
                        // S = 1 is a display shift, which the shadow does not model
                        if (bus_s[3]) begin
                            addr_s = addr;
                        end else if (bus_s[2]) begin
                            addr_s = addr_inc(addr);
                        end else begin
                            addr_s = addr_dec(addr);
                        end
                    end
                    8'b00001???: display_on_s = bus_s[2];
                    8'b000001??: inc_mode_s   = bus_s[1];
                    8'b0000001?: addr_s       = 7'h00;
                    8'b00000001: begin
                        line_1_s   = {16{BLANK_CHAR}};
                        line_2_s   = {16{BLANK_CHAR}};
                        addr_s     = 7'h00;
                        inc_mode_s = 1'b1;
                    end
                    default: addr_s = addr;
                endcase
            end else if (cgram_mode_r) begin
                addr_s = addr;
            end else begin
                // Only the two visible windows are shadowed; other writes are dropped
                if (addr[6:4] == 3'b000) begin
                    line_1_s[addr[3:0]] = bus_s[7:0];
                end else if (addr[6:4] == 3'b100) begin
                    line_2_s[addr[3:0]] = bus_s[7:0];
                    frame_done_s        = (addr[3:0] == 4'hF);
                end else begin
                    frame_done_s = 1'b0;
                end
                if (inc_mode_r) begin
                    addr_s = addr_inc(addr);
                end else begin
                    addr_s = addr_dec(addr);
                end
            end
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // Registered shadow, address counter, modes and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_1       <= {16{BLANK_CHAR}};
            line_2       <= {16{BLANK_CHAR}};
            addr         <= 7'h00;
            display_on   <= 1'b0;
            frame_done   <= 1'b0;
            err_4bit     <= 1'b0;
            err_addr     <= 1'b0;
            inc_mode_r   <= 1'b1;
            cgram_mode_r <= 1'b0;
        end else begin
            line_1       <= line_1_s;
            line_2       <= line_2_s;
            addr         <= addr_s;
            display_on   <= display_on_s;
            frame_done   <= frame_done_s;
            err_4bit     <= err_4bit_s;
            err_addr     <= err_addr_s;
            inc_mode_r   <= inc_mode_s;
            cgram_mode_r <= cgram_mode_s;
        end
    end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_monitor
// Drives HD44780-style bus transactions into lcd_bus_monitor and compares all
// outputs against a behavioural model of the LCD shadow on every clock.
// -----------------------------------------------------------------------------
module tb_lcd_bus_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       LCD_DATA = 8'h00;
    logic             LCD_RS = 1'b0;
    logic             LCD_RW = 1'b0;
    logic             LCD_EN = 1'b0;
    logic             LCD_ON = 1'b1;
    logic [15:0][7:0] line_1;
    logic [15:0][7:0] line_2;
    logic [6:0]       addr;
    logic             display_on;
    logic             frame_done;
    logic             err_4bit;
    logic             err_addr;

    lcd_bus_monitor #(.SYNC_STAGES(SYNC_STAGES), .BLANK_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_ON(LCD_ON),
        .line_1(line_1), .line_2(line_2), .addr(addr),
        .display_on(display_on), .frame_done(frame_done),
        .err_4bit(err_4bit), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int frame_cnt = 0;
    int frame_cyc = 0;
    logic check_en = 1'b0;

    // Behavioural model of the visible LCD state
    logic [7:0] m_l1 [16];
    logic [7:0] m_l2 [16];
    logic [6:0] m_addr;
    logic       m_inc, m_cg, m_disp, m_frame, m_e4, m_ea;
    logic [15:0][7:0] exp_p1, exp_p2;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            exp_p1[i] = m_l1[i];
            exp_p2[i] = m_l2[i];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic m_valid(input logic [6:0] a);
        int v = int'(a);
        return (v <= 39) || (v >= 64 && v <= 103);
    endfunction

    function automatic logic [6:0] m_step(input logic [6:0] a, input logic up);
        int v = int'(a);
        if (up) begin
            if (v == 39) v = 64;
            else if (v == 103) v = 0;
            else v = (v + 1) % 128;
        end else begin
            if (v == 0) v = 103;
            else if (v == 64) v = 39;
            else v = (v + 127) % 128;
        end
        return 7'(v);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_l1[i] = 8'h20;
            m_l2[i] = 8'h20;
        end
        m_addr = 7'd0; m_inc = 1'b1; m_cg = 1'b0; m_disp = 1'b0;
        m_frame = 1'b0; m_e4 = 1'b0; m_ea = 1'b0;
    endtask

    task automatic m_apply(input logic rs, input logic rw, input logic on, input logic [7:0] d);
        int v = int'(d);
        int a = int'(m_addr);
        if (!on || rw) return;
        if (!rs) begin
            if (v >= 128) begin
                m_addr = 7'(v - 128); m_cg = 1'b0;
                if (!m_valid(7'(v - 128))) m_ea = 1'b1;
            end else if (v >= 64) m_cg = 1'b1;
            else if (v >= 32) begin
                if ((v & 16) == 0) m_e4 = 1'b1;
            end else if (v >= 16) begin
                if ((v & 8) == 0) m_addr = m_step(m_addr, (v & 4) != 0);
            end else if (v >= 8) m_disp = (v & 4) != 0;
            else if (v >= 4) m_inc = (v & 2) != 0;
            else if (v >= 2) m_addr = 7'd0;
            else if (v == 1) begin
                for (int i = 0; i < 16; i++) begin
                    m_l1[i] = 8'h20;
                    m_l2[i] = 8'h20;
                end
                m_addr = 7'd0; m_inc = 1'b1;
            end
        end else if (!m_cg) begin
            if (a < 16) m_l1[a] = d;
            else if (a >= 64 && a < 80) begin
                m_l2[a - 64] = d;
                m_frame = (a == 79);
            end
            m_addr = m_step(m_addr, m_inc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("line_1", 128'(line_1), 128'(exp_p1));
            chk("line_2", 128'(line_2), 128'(exp_p2));
            chk("addr", 128'(addr), 128'(m_addr));
            chk("display_on", 128'(display_on), 128'(m_disp));
            chk("frame_done", 128'(frame_done), 128'(m_frame));
            chk("err_4bit", 128'(err_4bit), 128'(m_e4));
            chk("err_addr", 128'(err_addr), 128'(m_ea));
            if (frame_done === 1'b1) begin
                frame_cnt++;
                frame_cyc = cyc;
            end
        end
    end

    task automatic xfer(input logic rs, input logic rw, input logic on, input logic [7:0] d, input int hi);
        @(posedge clk); #1;
        LCD_RS = rs; LCD_RW = rw; LCD_ON = on; LCD_DATA = d; LCD_EN = 1'b1;
        repeat (hi) @(posedge clk);
        #1; LCD_EN = 1'b0; last_fall_cyc = cyc;
        repeat (LAT) @(posedge clk);
        #1; m_apply(rs, rw, on, d);
        @(posedge clk); #1; m_frame = 1'b0;
    endtask

    task automatic instr(input logic [7:0] d);
        xfer(1'b0, 1'b0, 1'b1, d, 2);
    endtask

    task automatic wr(input logic [7:0] d);
        xfer(1'b1, 1'b0, 1'b1, d, 2);
    endtask

    initial begin
        int r;
        logic [7:0] d;
        logic rs;
        m_reset();
        #2 rst = 1'b1;
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Clear, then "A".."P" across line 1
        instr(8'h01);
        for (int i = 0; i < 16; i++) wr(8'h41 + 8'(i));
        chk("lit_line1_alpha", 128'(line_1), 128'h504F4E4D4C4B4A494847464544434241);
        chk("lit_line2_blank", 128'(line_2), {16{8'h20}});
        chk("lit_addr_10", 128'(addr), 128'h10);
        chk("lit_no_frame", 128'(frame_cnt), 128'd0);

        // Line 2 fill ending at 0x4F produces one frame pulse
        instr(8'hC0);
        for (int i = 0; i < 16; i++) wr(8'h30 + 8'(i));
        chk("lit_line2_digits", 128'(line_2), 128'h3F3E3D3C3B3A39383736353433323130);
        chk("lit_frame_count", 128'(frame_cnt), 128'd1);
        chk("lit_frame_latency", 128'(frame_cyc - last_fall_cyc), 128'(SYNC_STAGES + 1));

        // Decrement mode wraps 0x00 -> 0x67, off-screen write discarded
        instr(8'h04);
        instr(8'h80);
        wr(8'h58);
        chk("lit_x_written", 128'(line_1[0]), 128'h58);
        chk("lit_addr_67", 128'(addr), 128'h67);
        wr(8'h59);
        chk("lit_addr_66", 128'(addr), 128'h66);

        // CGRAM writes leave the shadow alone; Set DDRAM leaves CGRAM mode
        instr(8'h40);
        for (int i = 0; i < 3; i++) wr(8'h61 + 8'(i));
        instr(8'h85);
        wr(8'h5A);
        chk("lit_line1_xz", 128'(line_1), 128'h504F4E4D4C4B4A4948475A4544434258);
        chk("lit_addr_04", 128'(addr), 128'h04);

        // Sticky error flags
        instr(8'h28);
        instr(8'hB0);
        chk("lit_addr_30", 128'(addr), 128'h30);
        instr(8'h06);
        instr(8'h0C);
        instr(8'h80);
        wr(8'h61);
        chk("lit_err_flags", 128'({err_4bit, err_addr, display_on}), 128'b111);

        // Reset while EN is high; EN falls during reset so the strobe is lost
        @(posedge clk); #1;
        LCD_RS = 1'b1; LCD_RW = 1'b0; LCD_ON = 1'b1; LCD_DATA = 8'h57; LCD_EN = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; m_reset();
        repeat (2) @(posedge clk);
        #1 LCD_EN = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("lit_reset_line1", 128'(line_1), {16{8'h20}});
        chk("lit_reset_state", 128'({addr, err_4bit, err_addr, display_on}), 128'd0);

        // Reads and unpowered strobes change nothing
        xfer(1'b1, 1'b1, 1'b1, 8'h51, 2);
        xfer(1'b1, 1'b0, 1'b0, 8'h51, 2);
        xfer(1'b0, 1'b0, 1'b0, 8'hC5, 2);
        chk("lit_ignored_line1", 128'(line_1), {16{8'h20}});
        chk("lit_ignored_addr", 128'(addr), 128'd0);

        // Short EN pulse while in CGRAM mode must not corrupt anything
        instr(8'h40);
        xfer(1'b1, 1'b0, 1'b1, 8'h21, 1);
        instr(8'h80);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            rs = 1'b0;
            if (r < 45) begin
                rs = 1'b1; d = 8'($urandom_range(32'h20, 32'h7E));
            end else if (r < 60) begin
                case ($urandom_range(0, 4))
                    0: d = 8'h80 | 8'($urandom_range(0, 15));
                    1: d = 8'hC0 | 8'($urandom_range(0, 15));
                    2: d = 8'h8F;
                    3: d = 8'hCF;
                    default: d = 8'h80 | 8'($urandom_range(0, 127));
                endcase
            end else if (r < 65) d = 8'h40 | 8'($urandom_range(0, 63));
            else if (r < 72) d = 8'h04 | 8'($urandom_range(0, 3));
            else if (r < 78) d = 8'h10 | 8'($urandom_range(0, 15));
            else if (r < 83) d = 8'h08 | 8'($urandom_range(0, 7));
            else if (r < 86) d = 8'h02 | 8'($urandom_range(0, 1));
            else if (r < 88) d = 8'h01;
            else if (r < 90) d = 8'h00;
            else if (r < 93) d = 8'h20 | 8'($urandom_range(0, 31));
            else begin
                d = 8'($urandom_range(0, 255)); rs = 1'($urandom_range(0, 1));
            end
            xfer(rs, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0), d,
                 int'($urandom_range(2, 4)));
        end

        repeat (4) @(posedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
